// File: rtl/pipe_pkg.sv
// Shared definitions for the flushable pipeline-stage register.
// Holds the stage-state enum, default bundle widths, the control-bundle
// field layout used by the ID/EX instance, and a helper that maps a
// stage state to the number of entries it holds.
package pipe_pkg;

    // Default widths of the control and data bundles.
    localparam int DEFAULT_CTRL_W = 16;
    localparam int DEFAULT_DATA_W = 128;

    // Control-bundle field offsets for the ID/EX instance.
    localparam int IDEX_REGWRITE_BIT = 0;
    localparam int IDEX_MEMREAD_BIT  = 1;
    localparam int IDEX_MEMWRITE_BIT = 2;
    localparam int IDEX_ALUOP_LSB    = 3;
    localparam int IDEX_ALUOP_W      = 3;
    localparam int IDEX_BRANCH_BIT   = 6;
    localparam int IDEX_JUMP_BIT     = 7;
    localparam int IDEX_DATATYPE_LSB = 8;
    localparam int IDEX_DATATYPE_W   = 2;

    // Stage state: how many of the two entries (main, skid) are valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    // Number of entries held in a given stage state.
    function automatic logic [1:0] stateOccupancy(input stage_state_t state);
        logic [1:0] count;
        count = 2'd0;
        case (state)
            EMPTY:   count = 2'd0;
            ONE:     count = 2'd1;
            FULL:    count = 2'd2;
            default: count = 2'd0;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the optional stage statistics.
// Counts cycles in which 'inc' is high and sticks at all-ones instead of
// wrapping; clears asynchronously when rst_n is low.
module pipe_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Increment on request until the all-ones ceiling is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + STEP;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flushable pipeline-stage register with a valid/ready handshake.
// A main entry feeds the next stage; a skid entry absorbs the one extra
// instruction that can arrive while downstream stalls, which lets in_ready
// depend only on registered state (plus flush). Flush drops everything and
// leaves a bubble with zeroed control.
// Optional statistics counters are built when PIPE_STAGE_STAT_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W            = DEFAULT_CTRL_W,
    parameter int DATA_W            = DEFAULT_DATA_W,
    parameter bit FLUSH_CLEARS_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STAT_EN
    ,
    output logic [31:0]       stat_stall_cyc,
    output logic [31:0]       stat_bubble_cyc,
    output logic [15:0]       stat_flush_cnt
`endif
);

    stage_state_t r_state;
    stage_state_t w_nextState;

    logic [CTRL_W-1:0] r_mainCtrl;
    logic [DATA_W-1:0] r_mainData;
    logic [CTRL_W-1:0] r_skidCtrl;
    logic [DATA_W-1:0] r_skidData;
    logic [1:0]        r_occupancy;

    logic w_mainValid;
    logic w_skidValid;
    logic w_inReady;
    logic w_acc;
    logic w_pop;
    logic w_loadMainIn;
    logic w_loadMainSkid;
    logic w_loadSkid;

    // Valid bits are a direct decode of the registered state.
    assign w_mainValid = (r_state != EMPTY);
    assign w_skidValid = (r_state == FULL);

    // Ready only depends on the registered skid bit and on flush.
    assign w_inReady = !w_skidValid && !flush;
    assign w_acc     = in_valid && w_inReady;
    assign w_pop     = w_mainValid && out_ready;

    // Stage state and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_occupancy <= 2'd0;
        end else begin
            r_state     <= w_nextState;
            r_occupancy <= stateOccupancy(w_nextState);
        end
    end

    // Next state and entry-load decisions; flush overrides every transfer.
    always_comb begin
        w_nextState    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        if (flush) begin
            w_nextState = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        w_nextState  = ONE;
                        w_loadMainIn = 1'b1;
                    end
                end
                ONE: begin
                    if (w_acc && w_pop) begin
                        w_nextState  = ONE;
                        w_loadMainIn = 1'b1;
                    end else if (w_acc) begin
                        w_nextState = FULL;
                        w_loadSkid  = 1'b1;
                    end else if (w_pop) begin
                        w_nextState = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_nextState    = ONE;
                        w_loadMainSkid = 1'b1;
                    end
                end
                default: begin
                    w_nextState = EMPTY;
                end
            endcase
        end
    end

    // Control registers: always zeroed on flush so a bubble never writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainCtrl <= '0;
            r_skidCtrl <= '0;
        end else if (flush) begin
            r_mainCtrl <= '0;
            r_skidCtrl <= '0;
        end else begin
            if (w_loadMainIn) begin
                r_mainCtrl <= in_ctrl;
            end else if (w_loadMainSkid) begin
                r_mainCtrl <= r_skidCtrl;
            end
            if (w_loadSkid) begin
                r_skidCtrl <= in_ctrl;
            end else if (w_loadMainSkid) begin
                r_skidCtrl <= '0;
            end
        end
    end

    // Data registers: on flush they are either zeroed or simply held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainData <= '0;
            r_skidData <= '0;
        end else if (flush) begin
            if (FLUSH_CLEARS_DATA) begin
                r_mainData <= '0;
                r_skidData <= '0;
            end
        end else begin
            if (w_loadMainIn) begin
                r_mainData <= in_data;
            end else if (w_loadMainSkid) begin
                r_mainData <= r_skidData;
            end
            if (w_loadSkid) begin
                r_skidData <= in_data;
            end else if (w_loadMainSkid) begin
                r_skidData <= '0;
            end
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = w_mainValid;
    assign out_ctrl  = w_mainValid ? r_mainCtrl : '0;
    assign out_data  = r_mainData;
    assign occupancy = r_occupancy;

`ifdef PIPE_STAGE_STAT_EN
    logic w_stallCyc;
    logic w_bubbleCyc;

    assign w_stallCyc  = w_mainValid && !out_ready;
    assign w_bubbleCyc = !w_mainValid && !flush;

    pipe_sat_counter #(.WIDTH(32)) u_stallCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stallCyc),
        .count (stat_stall_cyc)
    );

    pipe_sat_counter #(.WIDTH(32)) u_bubbleCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bubbleCyc),
        .count (stat_bubble_cyc)
    );

    pipe_sat_counter #(.WIDTH(16)) u_flushCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .count (stat_flush_cnt)
    );
`endif

endmodule
